au_decode_pipe: RTL and testbench

- Streaming, pipelined successor to the combinational AU_decode binary-to-vector decoder.
- Accepts a WIDTH-bit code on a valid/ready input channel and decodes it to a 2**WIDTH-bit vector.
- Output vector is one-hot, thermometer or one-cold, selected by MODE.
- Data passes through STAGES back-pressured register slices. Block sits between arithmetic-unit datapath stages that need a registered, flow-controlled decode.

---
 rtl/au_decode_pipe.sv | 115 +++++++++++
 tb/tb_au_decode_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_decode_pipe.sv
// au_decode_pipe
// Pipelined, back-pressured binary-to-vector decoder. Each accepted WIDTH-bit
// code is decoded (one-hot, thermometer or one-cold, chosen by MODE) and
// carried through STAGES register slices with valid/ready flow control.
// There is no skid buffer: the ready path runs combinationally through all stages.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous pipeline clear (drops every in-flight beat)
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle
//   a          code to decode
//   en         per-beat enable; 0 decodes to all-zero in every MODE
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   z          decoded vector (2**WIDTH bits)
//   beat_cnt   wrapping count of delivered beats (out_valid && out_ready)
module au_decode_pipe #(
    parameter int WIDTH     = 3,
    parameter int MODE      = 0,
    parameter int STAGES    = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic                  en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**WIDTH-1:0]   z,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    localparam int N = 2**WIDTH;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [N-1:0]      d [STAGES];
    logic [N-1:0]      dec;
    logic              accept;

    always_comb begin
        dec = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (MODE == 1) begin
                    dec[k] = (k <= int'(a));
                end else if (MODE == 2) begin
                    dec[k] = (k != int'(a));
                end else begin
                    dec[k] = (k == int'(a));
                end
            end
        end
    end

    // Stage i advances when it or any later stage is empty, or the output
    // drains. Written this way it is the same as "v[i]=0 or stage i+1
    // accepts", but it avoids a self-referencing vector.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            adv[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!v[j]) begin
                    adv[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = v[STAGES-1];
    assign z         = d[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
            end
            if (accept) begin
                d[0] <= dec;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    // Only move real data so an idle slot does not disturb z.
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (!flush && out_valid && out_ready) begin
            beat_cnt <= beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_au_decode_pipe.sv
module tb_au_decode_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] a = 3'd0;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;
    logic       run = 1'b0;

    logic       ir [4];
    logic       ov [4];
    logic [7:0] z_w [4];
    logic [3:0] bc_s [3];
    logic [7:0] bc_l;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instances 0..2: STAGES=2, CNT_WIDTH=4, MODE 0/1/2. Instance 3: STAGES=3, MODE 1.
    au_decode_pipe #(.WIDTH(3), .MODE(0), .STAGES(2), .CNT_WIDTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .en(en), .out_valid(ov[0]), .out_ready(out_ready), .z(z_w[0]), .beat_cnt(bc_s[0]));
    au_decode_pipe #(.WIDTH(3), .MODE(1), .STAGES(2), .CNT_WIDTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .en(en), .out_valid(ov[1]), .out_ready(out_ready), .z(z_w[1]), .beat_cnt(bc_s[1]));
    au_decode_pipe #(.WIDTH(3), .MODE(2), .STAGES(2), .CNT_WIDTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .en(en), .out_valid(ov[2]), .out_ready(out_ready), .z(z_w[2]), .beat_cnt(bc_s[2]));
    au_decode_pipe #(.WIDTH(3), .MODE(1), .STAGES(3), .CNT_WIDTH(8)) u3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
        .a(a), .en(en), .out_valid(ov[3]), .out_ready(out_ready), .z(z_w[3]), .beat_cnt(bc_l));

    // ---------------- behavioural model ----------------
    // Each instance is modelled as an ordered list of in-flight beats with an
    // age (edges since acceptance). The oldest beat is visible once it has
    // aged STAGES-1 edges; the block is ready when not flushing and either
    // not holding STAGES beats or the output is draining.
    int         st [4] = '{2, 2, 2, 3};
    int         md [4] = '{0, 1, 2, 1};
    int         cmask [4] = '{15, 15, 15, 255};
    logic [2:0] qa [4][8];
    logic       qe [4][8];
    int         qage [4][8];
    int         qn [4] = '{0, 0, 0, 0};
    int         mcnt [4] = '{0, 0, 0, 0};

    function automatic logic [7:0] ref_z(input int mode, input logic [2:0] code, input logic ena);
        int p;
        p = 1 << code;
        if (!ena) return 8'h00;
        if (mode == 1) return 8'((2 * p) - 1);
        if (mode == 2) return ~8'(p);
        return 8'(p);
    endfunction

    function automatic logic exp_ov(input int i);
        return (qn[i] > 0) && (qage[i][0] >= st[i] - 1);
    endfunction

    function automatic logic exp_ir(input int i);
        return !flush && ((qn[i] < st[i]) || out_ready);
    endfunction

    function automatic logic [7:0] exp_z(input int i);
        return ref_z(md[i], qa[i][0], qe[i][0]);
    endfunction

    function automatic int get_bc(input int i);
        if (i < 3) return int'(bc_s[i]);
        return int'(bc_l);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            logic acc;
            logic dlv;
            if (!rst_n) begin
                qn[i]   = 0;
                mcnt[i] = 0;
            end else begin
                acc = in_valid && exp_ir(i);
                dlv = exp_ov(i) && out_ready && !flush;
                if (flush) begin
                    qn[i] = 0;
                end else begin
                    if (dlv) begin
                        for (int k = 0; k < 7; k++) begin
                            qa[i][k]   = qa[i][k+1];
                            qe[i][k]   = qe[i][k+1];
                            qage[i][k] = qage[i][k+1];
                        end
                        qn[i]   = qn[i] - 1;
                        mcnt[i] = mcnt[i] + 1;
                    end
                    for (int k = 0; k < qn[i]; k++) qage[i][k] = qage[i][k] + 1;
                    if (acc) begin
                        qa[i][qn[i]]   = a;
                        qe[i][qn[i]]   = en;
                        qage[i][qn[i]] = 0;
                        qn[i]          = qn[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && run) begin
            for (int i = 0; i < 4; i++) begin
                chk("out_valid", i, 32'(ov[i]), 32'(exp_ov(i)));
                chk("in_ready", i, 32'(ir[i]), 32'(exp_ir(i)));
                chk("beat_cnt", i, 32'(get_bc(i)), 32'(mcnt[i] & cmask[i]));
                if (exp_ov(i)) chk("z", i, 32'(z_w[i]), 32'(exp_z(i)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_z", i, 32'(z_w[i]), 32'd0);
            chk("rst_beat_cnt", i, 32'(get_bc(i)), 32'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Single beat through an empty pipeline with out_ready high; literal
    // expectations for the three STAGES=2 instances.
    task automatic send_chk(input logic [2:0] code, input logic ena,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        out_ready = 1'b1;
        a = code; en = ena; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("lit_valid", 0, 32'(ov[0]), 32'd1);
        chk("lit_z", 0, 32'(z_w[0]), 32'(e0));
        chk("lit_z", 1, 32'(z_w[1]), 32'(e1));
        chk("lit_z", 2, 32'(z_w[2]), 32'(e2));
        idle(2);
    endtask

    task automatic send_n(input int n);
        out_ready = 1'b1;
        en = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = 3'($urandom_range(0, 7));
            in_valid = 1'b1;
            tick();
        end
        idle(4);
    endtask

    int cnt_before;

    initial begin
        #12;
        for (int i = 0; i < 4; i++) begin
            chk("reset_out_valid", i, 32'(ov[i]), 32'd0);
            chk("reset_z", i, 32'(z_w[i]), 32'd0);
            chk("reset_in_ready", i, 32'(ir[i]), 32'd1);
            chk("reset_beat_cnt", i, 32'(get_bc(i)), 32'd0);
        end
        rst_n = 1'b1;
        run = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream a=0..7, one-hot output with no gaps.
        out_ready = 1'b1; en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = 3'(k); in_valid = 1'b1;
            tick();
            if (k == 0) chk("stream_latency", 0, 32'(ov[0]), 32'd0);
            else begin
                chk("stream_valid", 0, 32'(ov[0]), 32'd1);
                chk("stream_z", 0, 32'(z_w[0]), 32'(8'h01 << (k - 1)));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_last_z", 0, 32'(z_w[0]), 32'h80);
        idle(3);
        chk("stream_cnt", 0, 32'(bc_s[0]), 32'd8);

        // Mode boundaries and en=0.
        send_chk(3'd0, 1'b1, 8'h01, 8'h01, 8'hFE);
        send_chk(3'd3, 1'b1, 8'h08, 8'h0F, 8'hF7);
        send_chk(3'd7, 1'b1, 8'h80, 8'hFF, 8'h7F);
        send_chk(3'd5, 1'b1, 8'h20, 8'h3F, 8'hDF);
        cnt_before = int'(bc_s[2]);
        send_chk(3'd5, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("en0_counted", 2, 32'(bc_s[2]), 32'((cnt_before + 1) & 15));

        // Exhaustive decode in every mode.
        for (int k = 0; k < 8; k++)
            send_chk(3'(k), 1'b1, ref_z(0, 3'(k), 1'b1), ref_z(1, 3'(k), 1'b1), ref_z(2, 3'(k), 1'b1));

        // Back-pressure: fill, hold, release.
        out_ready = 1'b0; en = 1'b1; in_valid = 1'b1;
        a = 3'd1; tick();
        a = 3'd2; tick();
        chk("bp_ready_low", 0, 32'(ir[0]), 32'd0);
        a = 3'd3; tick();
        chk("bp_hold_z", 0, 32'(z_w[0]), 32'h02);
        tick(); tick();
        chk("bp_stable_z", 0, 32'(z_w[0]), 32'h02);
        out_ready = 1'b1; #1;
        chk("bp_ready_same_cycle", 0, 32'(ir[0]), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_order2", 0, 32'(z_w[0]), 32'h04);
        tick();
        chk("bp_order3", 0, 32'(z_w[0]), 32'h08);
        idle(5);

        // Counter wrap on the 4-bit instances.
        do_reset();
        send_n(15);
        chk("wrap_15", 0, 32'(bc_s[0]), 32'd15);
        send_n(1);
        chk("wrap_16", 0, 32'(bc_s[0]), 32'd0);
        send_n(1);
        chk("wrap_17", 0, 32'(bc_s[0]), 32'd1);
        chk("wrap_17_wide", 3, 32'(bc_l), 32'd17);

        // Flush a full pipeline with in_valid and out_ready asserted.
        out_ready = 1'b0; in_valid = 1'b1; en = 1'b1;
        for (int k = 0; k < 3; k++) begin a = 3'(k + 4); tick(); end
        flush = 1'b1; out_ready = 1'b1; #1;
        for (int i = 0; i < 4; i++) chk("flush_ready", i, 32'(ir[i]), 32'd0);
        cnt_before = int'(bc_s[0]);
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("flush_valid", i, 32'(ov[i]), 32'd0);
            chk("flush_ready_after", i, 32'(ir[i]), 32'd1);
        end
        chk("flush_not_counted", 0, 32'(bc_s[0]), 32'(cnt_before));
        idle(2);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            in_valid  = 1'($urandom_range(0, 99) < 70);
            out_ready = 1'($urandom_range(0, 99) < 65);
            flush     = 1'($urandom_range(0, 99) < 3);
            en        = 1'($urandom_range(0, 99) < 90);
            a         = 3'($urandom_range(0, 7));
            tick();
        end
        flush = 1'b0;

        // Reset asserted mid-stream between edges.
        in_valid = 1'b1; out_ready = 1'b1; en = 1'b1; a = 3'd6;
        tick(); tick(); tick();
        do_reset();
        idle(3);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
